// File: rtl/gel_pkg.sv
// Gel pump scheduler shared types.
// Station count and FSM state encoding.
package gel_pkg;

  localparam int NUM_STATIONS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOSE = 2'd1,
    COOL = 2'd2
  } state_t;

endpackage

// File: rtl/gel_pump_sched_if.sv
// Station request / pump status bundle.
// master drives requests, slave is the scheduler.
interface gel_pump_sched_if;
  import gel_pkg::*;

  logic [NUM_STATIONS-1:0] req;
  logic                    refill;
  logic                    bomba;
  logic [NUM_STATIONS-1:0] grant;
  logic [NUM_STATIONS-1:0] done;
  logic                    busy;
  logic                    low_gel;
  logic                    empty;

  modport master (
    output req, refill,
    input  bomba, grant, done,
    input  busy, low_gel, empty
  );

  modport slave (
    input  req, refill,
    output bomba, grant, done,
    output busy, low_gel, empty
  );

endinterface

// File: rtl/dose_timer.sv
// Loadable down-counter with zero flag.
// Holds at zero until the next load.
module dose_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gel_pump_sched.sv
// Two-station gel pump scheduler.
// Round-robin grant, fixed dose and cooldown, reservoir tracking.
module gel_pump_sched
  import gel_pkg::*;
#(
  parameter int DOSE_CYCLES     = 50_000_000,
  parameter int COOLDOWN_CYCLES = 25_000_000,
  parameter int DOSE_LIMIT      = 200,
  parameter int LOW_MARGIN      = 20
) (
  input logic              clk,
  input logic              reset,
  gel_pump_sched_if.slave  bus
);

  localparam int CW   = $clog2(DOSE_LIMIT + 1);
  localparam int MAXC = (DOSE_CYCLES > COOLDOWN_CYCLES) ?
                        DOSE_CYCLES : COOLDOWN_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0] DOSE_LD = TW'(DOSE_CYCLES - 1);
  localparam logic [TW-1:0] COOL_LD = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [CW-1:0] LIMIT   = CW'(DOSE_LIMIT);

  state_t state, state_n;

  logic [NUM_STATIONS-1:0] armed;
  logic [NUM_STATIONS-1:0] elig;
  logic [NUM_STATIONS-1:0] pick;
  logic [NUM_STATIONS-1:0] grant_q;
  logic [NUM_STATIONS-1:0] done_q;
  logic                    last;
  logic                    bomba_q;
  logic [CW-1:0]           count;
  logic [CW-1:0]           rem;
  logic                    low_q;
  logic                    empty_q;
  logic                    t_load;
  logic [TW-1:0]           t_val;
  logic                    t_zero;
  logic                    start;
  logic                    finish;

  dose_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .val   (t_val),
    .zero  (t_zero)
  );

  assign elig = bus.req & armed
              & {NUM_STATIONS{~empty_q}}
              & {NUM_STATIONS{state == IDLE}};

  // On a tie the station not served last wins.
  always_comb begin
    unique case (1'b1)
      elig == 2'b11: pick = last ? 2'b01 : 2'b10;
      elig == 2'b01: pick = 2'b01;
      elig == 2'b10: pick = 2'b10;
      default:       pick = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    t_load  = 1'b0;
    t_val   = DOSE_LD;
    start   = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick != '0) begin
          state_n = DOSE;
          t_load  = 1'b1;
          start   = 1'b1;
        end
      end
      DOSE: begin
        if (t_zero) begin
          state_n = COOL;
          t_load  = 1'b1;
          t_val   = COOL_LD;
          finish  = 1'b1;
        end
      end
      COOL: begin
        if (t_zero) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant_q <= '0;
      bomba_q <= 1'b0;
      done_q  <= '0;
      armed   <= '0;
      last    <= 1'b1;
    end else begin
      state  <= state_n;
      done_q <= finish ? grant_q : '0;
      armed  <= (armed & ~pick) | ~bus.req;
      if (start) begin
        grant_q <= pick;
        bomba_q <= 1'b1;
        last    <= pick[1];
      end else if (state_n != DOSE) begin
        grant_q <= '0;
        bomba_q <= 1'b0;
      end
    end
  end

  assign rem = LIMIT - count;

  // Refill wins over a coincident dose completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      low_q   <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      if (bus.refill) begin
        count <= '0;
      end else if (finish && count != LIMIT) begin
        count <= count + CW'(1);
      end
      low_q   <= (rem != '0) && (int'(rem) <= LOW_MARGIN);
      empty_q <= (rem == '0);
    end
  end

  assign bus.bomba   = bomba_q;
  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state != IDLE);
  assign bus.low_gel = low_q;
  assign bus.empty   = empty_q;

endmodule

// File: doc/gel_pump_sched.md
GEL_PUMP_SCHED -- requirements
Module: gel_pump_sched

Interface
REQ-001 Parameter DOSE_CYCLES, default 50_000_000, clk cycles the pump runs per dose.
REQ-002 Parameter COOLDOWN_CYCLES, default 25_000_000, idle clk cycles after a dose before the next grant.
REQ-003 Parameter DOSE_LIMIT, default 200, doses per full reservoir.
REQ-004 Parameter LOW_MARGIN, default 20, remaining doses at which low_gel asserts.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  2  per-station hand-sensor level, already synchronised, 1 = hand present.
REQ-008 refill  input  1  one-cycle pulse, reservoir refilled.
REQ-009 bomba  output  1  pump enable, registered.
REQ-010 grant  output  2  one-hot station being served, 0 when none.
REQ-011 done  output  2  one-cycle pulse per station on dose completion.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 low_gel  output  1  remaining doses <= LOW_MARGIN and > 0.
REQ-014 empty  output  1  remaining doses == 0.

Function
REQ-015 States: IDLE, DOSE, COOL; any illegal encoding returns to IDLE next cycle.
REQ-016 Each station has an armed flag; it sets on any cycle its req is 0 and clears when that station is granted.
REQ-017 A station is eligible in IDLE when req=1, armed=1 and empty=0.
REQ-018 If eligible in IDLE at cycle N, the FSM enters DOSE at N+1 with grant and bomba high from N+1.
REQ-019 With both stations eligible, grant goes to the station not served last; after reset, station 0 wins the first tie.
REQ-020 DOSE lasts exactly DOSE_CYCLES cycles; req dropping mid-dose does not shorten it.
REQ-021 On DOSE->COOL, bomba and grant drop, done pulses for the served station for one cycle, and the dose count increments.
REQ-022 COOL lasts exactly COOLDOWN_CYCLES cycles with bomba=0, then IDLE; requests during COOL are not granted until IDLE.
REQ-023 A hand held continuously through a dose is not served again until its req has been 0 for at least one cycle.
REQ-024 Dose count width is $clog2(DOSE_LIMIT+1); it saturates at DOSE_LIMIT.
REQ-025 refill clears the dose count in any state; refill coincident with a DOSE->COOL increment leaves the count 0.
REQ-026 refill does not abort an active DOSE or COOL.
REQ-027 empty blocks new grants only; a dose already in progress completes.
REQ-028 low_gel and empty are registered, updated the cycle after the count changes.

Reset
REQ-029 While reset=0: state IDLE, bomba=0, grant=0, done=0, busy=0, dose count 0, low_gel=0, empty=0, armed flags 0, last-served pointer = station 1.
REQ-030 Reset asserted mid-DOSE deasserts bomba asynchronously, without waiting for a clock edge.
REQ-031 After reset release, a station becomes eligible only after a cycle with its req=0.

Structure
REQ-032 Shared package gel_pkg holds the state enumeration and the station-count constant NUM_STATIONS=2.
REQ-033 One sub-module, dose_timer: loadable down-counter with a zero flag, reused for the DOSE and COOL durations.

Verification (DOSE_CYCLES=4, COOLDOWN_CYCLES=3, DOSE_LIMIT=5, LOW_MARGIN=2)
REQ-034 Stimulus: req=01 after an idle cycle. Required: bomba high 4 cycles, grant=01, done=01 pulse, busy 7 cycles, count=1.
REQ-035 Stimulus: req=11 from IDLE, held, with each station dropped one cycle after its dose. Required: station 0 served, then station 1 after cooldown; strict alternation.
REQ-036 Stimulus: req=01 held for 20 cycles. Required: exactly one dose; a second dose only after req toggles to 0 and back.
REQ-037 Stimulus: 3 doses. Required: low_gel=1. Stimulus: 5 doses. Required: empty=1 and a further req gives no grant. Stimulus: refill. Required: empty=0, low_gel=0, grants resume.
REQ-038 Stimulus: refill on the DOSE->COOL edge. Required: count 0. Stimulus: reset=0 at dose cycle 2. Required: bomba=0 immediately, all outputs at reset values.
